kronos_if_fetch: RTL and testbench

Instruction fetch stage of the Kronos pipeline. It sits directly upstream of the decode stage.
- Generates sequential PCs and issues single-outstanding requests on the instruction memory port.
- Packs {pc, ir} into a pipeIFID_t and presents it on a valid/ready handshake to decode.
- Handles branch redirects from execute, with a one-entry skid buffer absorbing back-pressure.

---
 rtl/kronos_if_fetch_pkg.sv | 19 +
 rtl/kronos_if_fetch.sv | 120 ++++++++++++
 tb/tb_kronos_if_fetch.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kronos_if_fetch_pkg.sv
// Shared types for the Kronos fetch stage: the IF/ID pipeline word and fetch FSM states.
package kronos_if_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } pipeIFID_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/kronos_if_fetch.sv
// Kronos instruction fetch: single-outstanding memory requests, IF/ID output register
// with a one-entry skid buffer, and branch redirect handling.
module kronos_if_fetch
  import kronos_if_fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr_addr,
  output logic        instr_req,
  input  logic        instr_ack,
  input  logic [31:0] instr_data,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output pipeIFID_t   fetch,
  output logic        pipe_out_vld,
  input  logic        pipe_out_rdy
);

  fetch_state_e r_state;
  logic         r_run;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_redirect_pc;
  pipeIFID_t    r_out;
  logic         r_out_vld;
  pipeIFID_t    r_skid;
  logic         r_skid_vld;

  logic         w_ack;
  logic         w_drain;
  logic [31:0]  w_target;
  pipeIFID_t    w_word;

  // r_run holds the request off for the first cycle after reset
  assign instr_req    = r_run & (r_state != STALL);
  assign instr_addr   = r_fetch_pc;
  assign fetch        = r_out;
  assign pipe_out_vld = r_out_vld;

  assign w_ack    = instr_req & instr_ack;
  assign w_drain  = r_out_vld & pipe_out_rdy;
  assign w_target = word_align(branch_target);
  assign w_word   = '{pc: r_fetch_pc, ir: instr_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FETCH;
      r_run         <= 1'b0;
      r_fetch_pc    <= BOOT_ADDR;
      r_redirect_pc <= BOOT_ADDR;
      r_out         <= '0;
      r_out_vld     <= 1'b0;
      r_skid        <= '0;
      r_skid_vld    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (branch) begin
        // Redirect kills everything buffered, even if decode takes it this cycle
        r_out_vld  <= 1'b0;
        r_skid_vld <= 1'b0;
        case (r_state)
          FETCH: begin
            if (w_ack) begin
              r_fetch_pc <= w_target;
            end else begin
              r_redirect_pc <= w_target;
              r_state       <= FLUSH;
            end
          end
          STALL: begin
            r_fetch_pc <= w_target;
            r_state    <= FETCH;
          end
          default: begin
            r_redirect_pc <= w_target;
            if (w_ack) begin
              r_fetch_pc <= w_target;
              r_state    <= FETCH;
            end
          end
        endcase
      end else begin
        case (r_state)
          FETCH: begin
            if (w_ack) begin
              r_fetch_pc <= r_fetch_pc + 32'd4;
              if (!r_out_vld || pipe_out_rdy) begin
                r_out     <= w_word;
                r_out_vld <= 1'b1;
              end else begin
                r_skid     <= w_word;
                r_skid_vld <= 1'b1;
                r_state    <= STALL;
              end
            end else if (w_drain) begin
              r_out_vld <= 1'b0;
            end
          end
          STALL: begin
            if (pipe_out_rdy) begin
              r_out      <= r_skid;
              r_skid_vld <= 1'b0;
              r_state    <= FETCH;
            end
          end
          default: begin
            // Stale request completes here; its data is dropped
            if (w_drain) r_out_vld <= 1'b0;
            if (w_ack) begin
              r_fetch_pc <= r_redirect_pc;
              r_state    <= FETCH;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kronos_if_fetch.sv
// Scoreboard bench for kronos_if_fetch: program-order fetch model with branch kill semantics.
module tb_kronos_if_fetch;
  import kronos_if_fetch_pkg::*;

  localparam logic [31:0] BOOT = 32'h0000_0100;
  localparam logic [31:0] KEY  = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic        instr_ack;
  logic [31:0] instr_data;
  logic        branch = 1'b0;
  logic [31:0] branch_target = 32'h0;
  pipeIFID_t   fetch;
  logic        pipe_out_vld;
  logic        pipe_out_rdy = 1'b1;

  kronos_if_fetch #(.BOOT_ADDR(BOOT)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_addr   (instr_addr),
    .instr_req    (instr_req),
    .instr_ack    (instr_ack),
    .instr_data   (instr_data),
    .branch       (branch),
    .branch_target(branch_target),
    .fetch        (fetch),
    .pipe_out_vld (pipe_out_vld),
    .pipe_out_rdy (pipe_out_rdy)
  );

  always #5 clk = ~clk;

  // Memory: answers after mem_lat wait cycles; random ack noise while idle
  int   lat_lo = 0;
  int   lat_hi = 0;
  int   mem_cnt = 0;
  int   mem_lat = 0;
  logic junk_ack = 1'b0;

  assign instr_data = instr_addr ^ KEY;
  assign instr_ack  = instr_req ? (mem_cnt >= mem_lat) : junk_ack;

  always @(posedge clk) begin
    junk_ack <= 1'($urandom_range(1, 0));
    if (rst) begin
      mem_cnt <= 0;
      mem_lat <= int'($urandom_range(lat_hi, lat_lo));
    end else if (!instr_req) begin
      mem_cnt <= 0;
    end else if (instr_ack) begin
      mem_cnt <= 0;
      mem_lat <= int'($urandom_range(lat_hi, lat_lo));
    end else begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference model and monitor
  pipeIFID_t   exp_q[$];
  logic [31:0] m_pc = BOOT;
  logic [31:0] disc_addr = 32'h0;
  bit          disc = 1'b0;
  bit          prev_rst = 1'b0, prev_branch = 1'b0, prev_hold = 1'b0;
  bit          prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  pipeIFID_t   prev_fetch = '0;
  int          cyc = 0, first_vld_cyc = -1, last_xfer_cyc = -1;
  int          exp_spacing = 0, n_xfer = 0;
  bit          saw_zero_pc = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        chk("rst_req", 64'(instr_req), 64'(0));
        chk("rst_vld", 64'(pipe_out_vld), 64'(0));
        chk("rst_fetch", fetch, 64'(0));
        chk("rst_addr", 64'(instr_addr), 64'(BOOT));
        cyc = 0;
        first_vld_cyc = -1;
        last_xfer_cyc = -1;
      end else begin
        cyc++;
      end
      if (rst) begin
        exp_q.delete();
        m_pc = BOOT;
        disc = 1'b0;
        prev_branch = 1'b0;
        prev_hold = 1'b0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
      end else begin
        if (prev_branch) chk("vld_after_branch", 64'(pipe_out_vld), 64'(0));
        if (prev_hold && !prev_branch) begin
          chk("hold_vld", 64'(pipe_out_vld), 64'(1));
          chk("hold_fetch", fetch, prev_fetch);
        end
        if (pipe_out_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (pipe_out_vld && pipe_out_rdy) begin
          chk("out_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            pipeIFID_t e;
            e = exp_q.pop_front();
            chk("out_pc", 64'(fetch.pc), 64'(e.pc));
            chk("out_ir", 64'(fetch.ir), 64'(e.ir));
          end
          if (exp_spacing > 0 && last_xfer_cyc >= 0)
            chk("out_spacing", 64'(cyc - last_xfer_cyc), 64'(exp_spacing));
          last_xfer_cyc = cyc;
          n_xfer++;
          if (fetch.pc == 32'h0) saw_zero_pc = 1'b1;
        end
        if (prev_req && !prev_ack && instr_req)
          chk("addr_stable", 64'(instr_addr), 64'(prev_addr));
        if (instr_req && instr_ack) begin
          if (disc) begin
            chk("flush_addr", 64'(instr_addr), 64'(disc_addr));
            disc = 1'b0;
          end else begin
            chk("fetch_addr", 64'(instr_addr), 64'(m_pc));
            if (!branch) begin
              pipeIFID_t e;
              e.pc = m_pc;
              e.ir = m_pc ^ KEY;
              exp_q.push_back(e);
            end
            m_pc = m_pc + 32'd4;
          end
        end
        if (branch) begin
          exp_q.delete();
          if (instr_req && !instr_ack && !disc) begin
            disc = 1'b1;
            disc_addr = m_pc;
          end
          m_pc = {branch_target[31:2], 2'b00};
        end
        prev_branch = branch;
        prev_hold   = pipe_out_vld && !pipe_out_rdy;
        prev_fetch  = fetch;
        prev_req    = instr_req;
        prev_ack    = instr_ack;
        prev_addr   = instr_addr;
      end
      prev_rst = rst;
    end
  end

  // Stimulus
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int lo, input int hi);
    lat_lo = lo;
    lat_hi = hi;
    branch = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_vld(input string name);
    int k = 0;
    while (!pipe_out_vld && k < 50) begin
      tick();
      k++;
    end
    chk(name, 64'(pipe_out_vld), 64'(1));
  endtask

  task automatic pulse_branch(input logic [31:0] tgt);
    branch = 1'b1;
    branch_target = tgt;
    tick();
    branch = 1'b0;
  endtask

  initial begin
    int base;
    int k;

    // Zero-wait streaming, first-output latency and throughput
    pipe_out_rdy = 1'b1;
    exp_spacing = 1;
    do_reset(0, 0);
    base = n_xfer;
    tick(12);
    chk("first_vld_latency", 64'(first_vld_cyc), 64'(2));
    chk("stream_count", 64'(n_xfer - base), 64'(10));
    exp_spacing = 0;

    // Back-pressure fills the skid and stops requests
    do_reset(0, 0);
    wait_vld("bp_first_vld");
    pipe_out_rdy = 1'b0;
    tick(5);
    chk("bp_req_low", 64'(instr_req), 64'(0));
    chk("bp_hold_pc", 64'(fetch.pc), 64'(BOOT));
    chk("bp_buffered", 64'(exp_q.size()), 64'(2));
    pipe_out_rdy = 1'b1;
    tick(6);

    // Three wait states per request
    exp_spacing = 4;
    do_reset(3, 3);
    base = n_xfer;
    tick(40);
    chk("wait_count", 64'(n_xfer - base), 64'(9));
    exp_spacing = 0;

    // Branch while a request is pending
    do_reset(3, 3);
    k = 0;
    while (!(instr_req && instr_addr == BOOT + 32'd8) && k < 100) begin
      tick();
      k++;
    end
    chk("pend_reach_108", 64'(instr_addr), 64'(BOOT + 32'd8));
    pulse_branch(32'h0000_2002);
    base = n_xfer;
    tick(20);
    chk("pend_progress", 64'(n_xfer > base), 64'(1));

    // Branch while stalled, then branch coincident with an ack
    do_reset(0, 0);
    wait_vld("stall_first_vld");
    pipe_out_rdy = 1'b0;
    tick(3);
    chk("stall_req_low", 64'(instr_req), 64'(0));
    pulse_branch(32'h0000_3000);
    pipe_out_rdy = 1'b1;
    tick(8);
    chk("ack_branch_req", 64'(instr_req && instr_ack), 64'(1));
    pulse_branch(32'h0000_4000);
    tick(6);

    // Reset pulse during a wait state, then PC wrap through a branch
    do_reset(3, 3);
    tick(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_vld("rst_restart_vld");
    saw_zero_pc = 1'b0;
    pulse_branch(32'hFFFF_FFF8);
    tick(30);
    chk("pc_wrap_seen", 64'(saw_zero_pc), 64'(1));

    // Randomized traffic
    do_reset(0, 3);
    tick(2);
    for (int i = 0; i < 400; i++) begin
      pipe_out_rdy = ($urandom_range(3, 0) != 0);
      branch = ($urandom_range(15, 0) == 0);
      branch_target = $urandom;
      tick();
    end
    branch = 1'b0;
    pipe_out_rdy = 1'b1;
    base = n_xfer;
    tick(20);
    chk("rand_drain_progress", 64'(n_xfer > base), 64'(1));
    chk("rand_drain_depth", 64'(exp_q.size() <= 1), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1);
  end

endmodule
